aes_key_sched_ctrl: RTL and testbench

- Iterative AES-256 key-schedule controller.
- Latches a 256-bit cipher key and streams the 15 round keys (indices 0–14) to the cipher datapath over a valid/ready handshake.
- Computes each new round key from the previous two, borrowing the SubWord function from the S-box that it shares with the cipher's SubBytes stage.
- Sits between the key register interface and the round datapath, replacing purely combinational per-round key generation.

---
 rtl/aes_key_sched_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-256 key-schedule controller: streams round keys 0..14 over valid/ready
// and borrows a shared S-box for SubWord. Optional replay cache: AES_KEYSCHED_CACHE_EN.
module aes_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic         key_load,
    output logic         key_ready,
    input  logic         rk_start,
    output logic         key_valid,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         sbox_req,
    output logic [31:0]  sbox_in,
    input  logic         sbox_gnt,
    input  logic [31:0]  sbox_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_SBOX  = 2'd2;
    localparam logic [3:0] LAST_IDX = 4'd14;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic [1:0]   state_q,     state_d;
    logic [255:0] key_reg_q,   key_reg_d;
    logic         key_valid_q, key_valid_d;
    logic [127:0] prev0_q,     prev0_d;
    logic [127:0] prev1_q,     prev1_d;
    logic [7:0]   rcon_q,      rcon_d;
    logic [127:0] rk_data_q,   rk_data_d;
    logic [3:0]   rk_idx_q,    rk_idx_d;
    logic         rk_valid_q,  rk_valid_d;
    logic         rk_last_q,   rk_last_d;
    logic         sbox_req_q,  sbox_req_d;
    logic [31:0]  sbox_in_q,   sbox_in_d;
    logic         key_ready_q, key_ready_d;
    logic         busy_q,      busy_d;

    logic [3:0]   n_s;
    logic [31:0]  t_s, k0_s, k1_s, k2_s, k3_s;

`ifdef AES_KEYSCHED_CACHE_EN
    logic [127:0] cache_q [0:14];
    logic         cache_ok_q, cache_ok_d;
    logic         replay_q,   replay_d;
    logic         cache_we_s;
`endif

    assign n_s = rk_idx_q + 4'd1;

    // Next round key from the two previous ones; even rounds rotate and add rcon
    always_comb begin
        if (rk_idx_q[0]) begin
            t_s = {sbox_out[23:0], sbox_out[31:24]} ^ {rcon_q, 24'h000000};
        end else begin
            t_s = sbox_out;
        end
        k0_s = prev0_q[127:96] ^ t_s;
        k1_s = prev0_q[95:64]  ^ k0_s;
        k2_s = prev0_q[63:32]  ^ k1_s;
        k3_s = prev0_q[31:0]   ^ k2_s;
    end

    // Control FSM and next-state of all registered outputs
    always_comb begin
        state_d     = state_q;
        key_reg_d   = key_reg_q;
        key_valid_d = key_valid_q;
        prev0_d     = prev0_q;
        prev1_d     = prev1_q;
        rcon_d      = rcon_q;
        rk_data_d   = rk_data_q;
        rk_idx_d    = rk_idx_q;
`ifdef AES_KEYSCHED_CACHE_EN
        cache_ok_d  = cache_ok_q;
        replay_d    = replay_q;
        cache_we_s  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    key_reg_d   = key_in;
                    key_valid_d = 1'b1;
`ifdef AES_KEYSCHED_CACHE_EN
                    cache_ok_d  = 1'b0;
`endif
                end else if (rk_start && key_valid_q) begin
                    rk_data_d = key_reg_q[255:128];
                    rk_idx_d  = 4'd0;
                    prev0_d   = key_reg_q[255:128];
                    prev1_d   = key_reg_q[127:0];
                    rcon_d    = 8'h01;
                    state_d   = ST_EMIT;
`ifdef AES_KEYSCHED_CACHE_EN
                    replay_d  = cache_ok_q;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
`ifdef AES_KEYSCHED_CACHE_EN
                    cache_we_s = !replay_q;
`endif
                    if (rk_idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
`ifdef AES_KEYSCHED_CACHE_EN
                        cache_ok_d = 1'b1;
                        replay_d   = 1'b0;
                    end else if (replay_q) begin
                        rk_data_d = cache_q[n_s];
                        rk_idx_d  = n_s;
`endif
                    end else if (rk_idx_q == 4'd0) begin
                        rk_data_d = prev1_q;
                        rk_idx_d  = 4'd1;
                    end else begin
                        state_d = ST_SBOX;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_SBOX: begin
                if (sbox_gnt) begin
                    rk_data_d = {k0_s, k1_s, k2_s, k3_s};
                    rk_idx_d  = n_s;
                    prev0_d   = prev1_q;
                    prev1_d   = {k0_s, k1_s, k2_s, k3_s};
                    if (rk_idx_q[0]) begin
                        rcon_d = xtime(rcon_q);
                    end else begin
                        rcon_d = rcon_q;
                    end
                    state_d   = ST_EMIT;
                end else begin
                    state_d = ST_SBOX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rk_valid_d  = (state_d == ST_EMIT);
        rk_last_d   = (state_d == ST_EMIT) && (rk_idx_d == LAST_IDX);
        sbox_req_d  = (state_d == ST_SBOX);
        sbox_in_d   = (state_d == ST_SBOX) ? prev1_d[31:0] : 32'h0;
        key_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_reg_q   <= 256'h0;
            key_valid_q <= 1'b0;
            prev0_q     <= 128'h0;
            prev1_q     <= 128'h0;
            rcon_q      <= 8'h01;
            rk_data_q   <= 128'h0;
            rk_idx_q    <= 4'd0;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            sbox_req_q  <= 1'b0;
            sbox_in_q   <= 32'h0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_reg_q   <= key_reg_d;
            key_valid_q <= key_valid_d;
            prev0_q     <= prev0_d;
            prev1_q     <= prev1_d;
            rcon_q      <= rcon_d;
            rk_data_q   <= rk_data_d;
            rk_idx_q    <= rk_idx_d;
            rk_valid_q  <= rk_valid_d;
            rk_last_q   <= rk_last_d;
            sbox_req_q  <= sbox_req_d;
            sbox_in_q   <= sbox_in_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef AES_KEYSCHED_CACHE_EN
    // Round-key cache, filled from computed keys as each one is handed over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                cache_q[i] <= 128'h0;
            end
            cache_ok_q <= 1'b0;
            replay_q   <= 1'b0;
        end else begin
            if (cache_we_s) begin
                cache_q[rk_idx_q] <= rk_data_q;
            end
            cache_ok_q <= cache_ok_d;
            replay_q   <= replay_d;
        end
    end
`endif

    assign key_ready = key_ready_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign rk_valid  = rk_valid_q;
    assign rk_data   = rk_data_q;
    assign rk_idx    = rk_idx_q;
    assign rk_last   = rk_last_q;
    assign sbox_req  = sbox_req_q;
    assign sbox_in   = sbox_in_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: AES-256 key expansion reference model,
// randomized handshake/grant stalls, mid-stream key_load and asynchronous reset.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_in;
    logic         key_load;
    logic         key_ready;
    logic         rk_start;
    logic         key_valid;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         sbox_req;
    logic [31:0]  sbox_in;
    logic         sbox_gnt;
    logic [31:0]  sbox_out;

    int n_total = 0;
    int n_bad   = 0;
    int gnt_mode = 0;   // 0: always grant, 1: withhold 3 cycles per request, 2: never

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] model_rk [0:14];
    logic [127:0] obs_rk   [0:14];

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
        .key_ready(key_ready), .rk_start(rk_start), .key_valid(key_valid), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx),
        .rk_last(rk_last), .sbox_req(sbox_req), .sbox_in(sbox_in), .sbox_gnt(sbox_gnt),
        .sbox_out(sbox_out)
    );

    assign sbox_out = {sbox_tab[sbox_in[31:24]], sbox_tab[sbox_in[23:16]],
                       sbox_tab[sbox_in[15:8]],  sbox_tab[sbox_in[7:0]]};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Textbook AES-256 key expansion into 60 words, grouped into 15 round keys
    task automatic build_model(input logic [255:0] k);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gf_mul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rk_valid"},  rk_valid,  1'b0);
        check_eq({tag, "_rk_data"},   rk_data,   128'h0);
        check_eq({tag, "_rk_idx"},    rk_idx,    4'd0);
        check_eq({tag, "_rk_last"},   rk_last,   1'b0);
        check_eq({tag, "_sbox_req"},  sbox_req,  1'b0);
        check_eq({tag, "_sbox_in"},   sbox_in,   32'h0);
        check_eq({tag, "_key_ready"}, key_ready, 1'b1);
        check_eq({tag, "_key_valid"}, key_valid, 1'b0);
        check_eq({tag, "_busy"},      busy,      1'b0);
    endtask

    task automatic load_key(input logic [255:0] k);
        @(negedge clk);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        build_model(k);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rk_start = 1'b1;
    endtask

    // Consume one 15-key stream; last_cyc is the cycle of the final handshake after start
    task automatic run_stream(input bit rand_rdy, input bit inject, input logic [255:0] inj_key,
                              output int last_cyc, output bit saw_req);
        int got;
        int ncyc;
        logic held_v;
        logic [127:0] held_d;
        logic [3:0] held_i;
        got = 0; ncyc = 0; held_v = 1'b0; held_d = 128'h0; held_i = 4'd0;
        saw_req = 1'b0; last_cyc = 0;
        while (got < 15 && ncyc < 400) begin
            @(negedge clk);
            ncyc++;
            rk_start = 1'b0;
            key_load = 1'b0;
            rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sbox_req) saw_req = 1'b1;
            if (held_v) begin
                check_eq("rk_data_hold", rk_data, held_d);
                check_eq("rk_idx_hold", rk_idx, held_i);
            end
            if (inject && rk_valid && rk_idx == 4'd5) begin
                key_in   = inj_key;
                key_load = 1'b1;
            end
            if (rk_valid && rk_ready) begin
                obs_rk[got] = rk_data;
                check_eq("rk_idx", rk_idx, 128'(got));
                check_eq("rk_data", rk_data, model_rk[got]);
                check_eq("rk_last", rk_last, (got == 14));
                got++;
                last_cyc = ncyc;
            end
            held_v = rk_valid && !rk_ready;
            held_d = rk_data;
            held_i = rk_idx;
        end
        if (got < 15) check_eq("stream_timeout", 128'(got), 128'd15);
        @(negedge clk);
        rk_ready = 1'b0;
        key_load = 1'b0;
        check_eq("idle_key_ready", key_ready, 1'b1);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_rk_valid", rk_valid, 1'b0);
    endtask

    // Shared S-box arbiter model; also checks sbox_in holds while a request stalls
    initial begin : gnt_drv
        int wait_cnt;
        logic [31:0] prev_in;
        logic prev_stall;
        wait_cnt = 0; prev_in = 32'h0; prev_stall = 1'b0;
        sbox_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall && sbox_req) check_eq("sbox_in_hold", sbox_in, prev_in);
            if (sbox_req) wait_cnt++;
            else wait_cnt = 0;
            case (gnt_mode)
                0:       sbox_gnt = 1'b1;
                1:       sbox_gnt = sbox_req ? (wait_cnt > 3) : 1'($urandom_range(0, 1));
                default: sbox_gnt = 1'b0;
            endcase
            prev_stall = sbox_req && !sbox_gnt;
            prev_in    = sbox_in;
        end
    end

    initial begin : main
        int lc;
        bit sr;
        int c;
        logic [255:0] k;
        logic [255:0] k2;
        rst_n = 1'b0; key_in = 256'h0; key_load = 1'b0; rk_start = 1'b0; rk_ready = 1'b0;
        build_sbox();
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;

        // rk_start with no key latched is ignored
        pulse_start();
        @(negedge clk);
        rk_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("nokey_busy", busy, 1'b0);
            check_eq("nokey_rk_valid", rk_valid, 1'b0);
        end

        // key_load beats rk_start in the same cycle
        @(negedge clk);
        key_in = FIPS_KEY; key_load = 1'b1; rk_start = 1'b1;
        @(negedge clk);
        key_load = 1'b0; rk_start = 1'b0;
        check_eq("both_key_valid", key_valid, 1'b1);
        check_eq("both_rk_valid", rk_valid, 1'b0);
        @(negedge clk);
        check_eq("both_rk_valid2", rk_valid, 1'b0);
        check_eq("both_busy", busy, 1'b0);
        build_model(FIPS_KEY);

        // FIPS-197 vector at full speed
        gnt_mode = 0;
        pulse_start();
        run_stream(1'b0, 1'b0, 256'h0, lc, sr);
        check_eq("fips_last_cycle", 128'(lc), 128'd28);
        check_eq("fips_sbox_used", sr, 1'b1);
        check_eq("fips_idx1", obs_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
        check_eq("fips_idx2", obs_rk[2], 128'ha573c29fa176c498a97fce93a572c09c);
        check_eq("fips_idx14", obs_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Same key, random back-pressure and withheld grants
        load_key(FIPS_KEY);
        gnt_mode = 1;
        pulse_start();
        run_stream(1'b1, 1'b0, 256'h0, lc, sr);
        check_eq("stall_sbox_used", sr, 1'b1);

        // Second start on the same key: replay from cache or recompute
        gnt_mode = 0;
        pulse_start();
        run_stream(1'b0, 1'b0, 256'h0, lc, sr);
`ifdef AES_KEYSCHED_CACHE_EN
        check_eq("replay_last_cycle", 128'(lc), 128'd14 + 128'd1);
        check_eq("replay_no_sbox", sr, 1'b0);
        load_key(FIPS_KEY);
        pulse_start();
        run_stream(1'b0, 1'b0, 256'h0, lc, sr);
        check_eq("reload_sbox_used", sr, 1'b1);
`else
        check_eq("rerun_last_cycle", 128'(lc), 128'd28);
        check_eq("rerun_sbox_used", sr, 1'b1);
`endif

        // Random keys with a key_load attempted mid-stream
        for (int it = 0; it < 3; it++) begin
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            load_key(k);
            gnt_mode = 1;
            pulse_start();
            run_stream(1'b1, 1'b1, k2, lc, sr);
            pulse_start();
            run_stream(1'b1, 1'b0, 256'h0, lc, sr);
        end

        // Asynchronous reset while waiting for the S-box at index 7
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        load_key(k);
        gnt_mode = 0;
        pulse_start();
        c = 0;
        while (!(sbox_req && rk_idx == 4'd7) && c < 200) begin
            @(negedge clk);
            c++;
            rk_start = 1'b0;
            rk_ready = 1'b1;
            if (rk_valid && rk_idx == 4'd7) gnt_mode = 2;
        end
        rk_ready = 1'b0;
        check_eq("reach_sbox_idx7", sbox_req && rk_idx == 4'd7, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        gnt_mode = 0;
        pulse_start();
        @(negedge clk);
        rk_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_busy", busy, 1'b0);
            check_eq("post_rst_rk_valid", rk_valid, 1'b0);
            check_eq("post_rst_key_valid", key_valid, 1'b0);
        end

        // Recovery after reset: full recompute of a fresh key
        load_key(k);
        pulse_start();
        run_stream(1'b0, 1'b0, 256'h0, lc, sr);
        check_eq("post_rst_sbox_used", sr, 1'b1);
        check_eq("post_rst_last_cycle", 128'(lc), 128'd28);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
